firmware_arbiter_m: RTL and testbench
=====================================

// Module: firmware_arbiter_m
// PURPOSE
//   Shares the single firmware ROM (14-bit address, 8-bit data, active-high select) between two requesters:
//   CPU instruction/data fetch (port C) and boot/DMA copier (port D).
//   Arbitrates, drives ROM address and select, waits ROM_WAIT cycles for data, captures data, returns a one-cycle ack.
//   Sits between the bus decoder and firmware ROM.
// PARAMETERS
//   ADDR_W      14  ROM address width
//   DATA_W      8   ROM data width
//   ROM_WAIT    2   cycles select+address held before data sampled; legal 1..15
//   MAX_STARVE  4   consecutive lost ties before D forced to win (fairness build only); legal 1..15
// PORTS
//   clk          in   1       single system clock; all state on rising edge
//   rst          in   1       synchronous, active-high reset
//   cpu_req      in   1       port C request; held high with cpu_addr stable until cpu_ack
//   cpu_addr     in   ADDR_W  port C address
//   cpu_ack      out  1       one-cycle pulse; cpu_data valid this cycle
//   cpu_data     out  DATA_W  last data read for port C; held until next C ack
//   dma_req      in   1       port D request; same rules as cpu_req
//   dma_addr     in   ADDR_W  port D address
//   dma_ack      out  1       one-cycle pulse; dma_data valid
//   dma_data     out  DATA_W  last data read for port D; held until next D ack
//   rom_address  out  ADDR_W  registered address to ROM
//   rom_data     in   DATA_W  ROM read data (combinational from rom_address)
//   rom_select   out  1       ROM select, high only in ACCESS
//   busy         out  1       high in ACCESS or DONE
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; data regs 0; starve count 0. Reset mid-access aborts it; no ack issued.
//   FSM IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE: if any req, grant winner, latch addr into rom_address, latch owner, wait cnt=0, go ACCESS.
//     Otherwise stay; rom_address holds last value.
//   ACCESS: rom_select=1; cnt increments each cycle.
//     On cycle where cnt==ROM_WAIT-1, capture rom_data into owner's data reg; go DONE.
//   DONE: owner ack=1 for exactly this cycle; reqs ignored; go IDLE.
//   Latency: req high in cycle 0 with arbiter IDLE -> ack in cycle ROM_WAIT+1.
//     Max throughput one access per ROM_WAIT+2 cycles.
//   Requester keeping req high through its ack cycle issues a new request, seen in the following IDLE.
//   Req dropped mid-access: access still completes and ack still pulses; data captured normally.
//   Simultaneous cpu_req & dma_req in IDLE: C wins (fixed priority) unless fairness override below.
//   Never both acks in the same cycle; rom_select never high in IDLE or DONE.
//   Address/data pass straight through; no width conversion; rom_address wraps naturally at 2^ADDR_W.
// CONFIGURATION
//   FIRMWARE_ARB_FAIRNESS_EN defined:
//     4-bit starve counter; +1 (saturating) each time C wins a tie while dma_req high.
//     When count==MAX_STARVE, next tie goes to D; counter clears on every D grant.
//   Undefined: strict C priority; no counter; D can starve indefinitely under continuous C traffic.
// STRUCTURE
//   Shared header firmware_arb_defs.vh: state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2),
//     owner IDs (OWN_CPU=1'b0, OWN_DMA=1'b1), ROM_WAIT/MAX_STARVE legality checks.
//   One sub-module: firmware_arb_grant_m: combinational winner select plus fairness starve counter
//     (counter present only under FIRMWARE_ARB_FAIRNESS_EN).
//   FSM, wait counter, data capture in top.
// TESTING
//   1. rst high 3 cycles mid-access -> all outputs 0, no ack afterwards, next C req served normally.
//   2. ROM_WAIT=2, C req addr 14'h0010 alone -> rom_select high cycles 1-2;
//      cpu_ack in cycle 3, cpu_data=ROM[0x10].
//   3. C and D req same cycle (0x0000/0x3FFF), fairness off -> C acked cycle 3, D acked cycle 7;
//      data matches ROM.
//   4. C held high continuously, D high, fairness off -> dma_ack never within 64 cycles;
//      fairness on, MAX_STARVE=4 -> D granted on 5th arbitration.
//   5. C req dropped after 1 cycle -> cpu_ack still pulses once; no second access.
//   6. Scoreboard: 200 random req/addr patterns on both ports -> every ack data equals ROM model,
//      no double ack, rom_select only in ACCESS.

Source files
------------

// File: rtl/firmware_arbiter_m_pkg.sv
// Shared definitions for the firmware ROM arbiter: FSM states, owner IDs,
// wait-counter width and parameter legality helper.
// Optional feature macro: FIRMWARE_ARB_FAIRNESS_EN (see firmware_arb_grant_m).
package firmware_arbiter_m_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } arb_owner_e;

   // Wait and starve counters both fit in 4 bits (legal range 1..15).
   localparam int unsigned CNT_W = 4;

   function automatic bit param_in_range(input int unsigned v);
      return (v >= 1) && (v <= 15);
   endfunction

endpackage

// File: rtl/firmware_arbiter_m_grant.sv
// Winner select between CPU (C) and DMA (D) requesters.
// Default: strict C priority. With FIRMWARE_ARB_FAIRNESS_EN defined, a
// saturating starve counter hands a tie to D after MAX_STARVE lost ties.
module firmware_arb_grant_m
   import firmware_arbiter_m_pkg::*;
#(
   parameter int unsigned MAX_STARVE = 4
)
(
   input  logic clk,
   input  logic rst,
   input  logic cpu_req_i,
   input  logic dma_req_i,
   input  logic take_i,
   output logic grant_o,
   output logic owner_o
);

   assign grant_o = cpu_req_i | dma_req_i;

`ifdef FIRMWARE_ARB_FAIRNESS_EN
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(MAX_STARVE);

   logic [CNT_W-1:0] starve_q, starve_d;
   logic             tie;

   assign tie = cpu_req_i & dma_req_i;

   // Winner: D alone, or D on a tie once C has won MAX_STARVE ties in a row.
   always_comb begin
      owner_o = OWN_CPU;
      if (dma_req_i && (!cpu_req_i || (starve_q == STARVE_LIM)))
         owner_o = OWN_DMA;
   end

   // Starve count: clear on any D grant, saturating +1 when C takes a tie.
   always_comb begin
      starve_d = starve_q;
      if (take_i) begin
         if (owner_o == OWN_DMA)
            starve_d = '0;
         else if (tie && (starve_q != '1))
            starve_d = starve_q + 1'b1;
      end
   end

   // Starve counter register.
   always_ff @(posedge clk) begin
      if (rst) starve_q <= '0;
      else     starve_q <= starve_d;
   end
`else
   logic unused_no_fairness;

   // Strict priority: D wins only when C is not requesting.
   always_comb begin
      owner_o = dma_req_i & ~cpu_req_i;
   end

   assign unused_no_fairness = &{1'b0, clk, rst, take_i};
`endif

endmodule

// File: rtl/firmware_arbiter_m.sv
// Firmware ROM arbiter: shares one ROM between CPU fetch (C) and DMA/boot
// copier (D). IDLE grants, ACCESS holds select/address for ROM_WAIT cycles
// and captures data, DONE pulses the owner's ack for one cycle.
// Optional feature macro: FIRMWARE_ARB_FAIRNESS_EN (D anti-starvation).
module firmware_arbiter_m
   import firmware_arbiter_m_pkg::*;
#(
   parameter int unsigned ADDR_W     = 14,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned ROM_WAIT   = 2,
   parameter int unsigned MAX_STARVE = 4
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_data,
   input  logic              dma_req,
   input  logic [ADDR_W-1:0] dma_addr,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_data,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [DATA_W-1:0] rom_data,
   output logic              rom_select,
   output logic              busy
);

   if (!param_in_range(ROM_WAIT)) begin : g_bad_rom_wait
      $error("firmware_arbiter_m: ROM_WAIT must be 1..15");
   end
   if (!param_in_range(MAX_STARVE)) begin : g_bad_max_starve
      $error("firmware_arbiter_m: MAX_STARVE must be 1..15");
   end

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ROM_WAIT - 1);

   arb_state_e        state_q, state_d;
   arb_owner_e        owner_q, owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
   logic [DATA_W-1:0] dma_data_q, dma_data_d;
   logic              grant, win, take;

   assign take = (state_q == IDLE) & grant;

   firmware_arb_grant_m #(
      .MAX_STARVE (MAX_STARVE)
   ) u_grant (
      .clk       (clk),
      .rst       (rst),
      .cpu_req_i (cpu_req),
      .dma_req_i (dma_req),
      .take_i    (take),
      .grant_o   (grant),
      .owner_o   (win)
   );

   // Next-state: grant in IDLE, count and capture in ACCESS, ack in DONE.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      cpu_data_d = cpu_data_q;
      dma_data_d = dma_data_q;
      case (state_q)
         IDLE: begin
            if (grant) begin
               owner_d = arb_owner_e'(win);
               addr_d  = win ? dma_addr : cpu_addr;
               cnt_d   = '0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == WAIT_LAST) begin
               if (owner_q == OWN_CPU) cpu_data_d = rom_data;
               else                    dma_data_d = rom_data;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any access in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= OWN_CPU;
         cnt_q      <= '0;
         addr_q     <= '0;
         cpu_data_q <= '0;
         dma_data_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         cpu_data_q <= cpu_data_d;
         dma_data_q <= dma_data_d;
      end
   end

   assign rom_address = addr_q;
   assign rom_select  = (state_q == ACCESS);
   assign busy        = (state_q == ACCESS) | (state_q == DONE);
   assign cpu_ack     = (state_q == DONE) & (owner_q == OWN_CPU);
   assign dma_ack     = (state_q == DONE) & (owner_q == OWN_DMA);
   assign cpu_data    = cpu_data_q;
   assign dma_data    = dma_data_q;

endmodule

// File: tb/tb_firmware_arbiter_m.sv
// Directed + random-scoreboard bench for firmware_arbiter_m (ROM_WAIT=2).
// Honours FIRMWARE_ARB_FAIRNESS_EN for the starvation test expectations.
module tb_firmware_arbiter_m;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, dma_req;
   logic [13:0] cpu_addr, dma_addr;
   logic        cpu_ack, dma_ack;
   logic [7:0]  cpu_data, dma_data;
   logic [13:0] rom_address;
   logic [7:0]  rom_data;
   logic        rom_select, busy;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   int unsigned cpu_acks = 0, dma_acks = 0, both_ack = 0, sel_bad = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_fn(input logic [13:0] a);
      return a[7:0] ^ {2'b00, a[13:8]} ^ 8'hA5;
   endfunction

   assign rom_data = rom_fn(rom_address);

   firmware_arbiter_m #(
      .ADDR_W     (14),
      .DATA_W     (8),
      .ROM_WAIT   (2),
      .MAX_STARVE (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_req     (cpu_req),
      .cpu_addr    (cpu_addr),
      .cpu_ack     (cpu_ack),
      .cpu_data    (cpu_data),
      .dma_req     (dma_req),
      .dma_addr    (dma_addr),
      .dma_ack     (dma_ack),
      .dma_data    (dma_data),
      .rom_address (rom_address),
      .rom_data    (rom_data),
      .rom_select  (rom_select),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (cpu_ack) cpu_acks++;
      if (dma_ack) dma_acks++;
      if (cpu_ack && dma_ack) both_ack++;
      if (rom_select && (!busy || cpu_ack || dma_ack)) sel_bad++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int unsigned c0, d0, sb_acks;
      logic [13:0] ca, da;

      rst = 1'b1; cpu_req = 1'b0; dma_req = 1'b0; cpu_addr = '0; dma_addr = '0;
      tick(); tick();
      check("rst_select",  32'(rom_select), 32'd0);
      check("rst_busy",    32'(busy), 32'd0);
      check("rst_acks",    32'({cpu_ack, dma_ack}), 32'd0);
      check("rst_addr",    32'(rom_address), 32'd0);
      check("rst_data",    32'({cpu_data, dma_data}), 32'd0);
      rst = 1'b0;
      tick();

      // single C access at 0x0010
      cpu_req = 1'b1; cpu_addr = 14'h0010;
      tick();
      check("c_sel_c1",  32'(rom_select), 32'd1);
      check("c_addr_c1", 32'(rom_address), 32'h0010);
      check("c_ack_c1",  32'(cpu_ack), 32'd0);
      tick();
      check("c_sel_c2",  32'(rom_select), 32'd1);
      tick();
      check("c_ack_c3",  32'(cpu_ack), 32'd1);
      check("c_data_c3", 32'(cpu_data), 32'hB5);
      check("c_sel_c3",  32'(rom_select), 32'd0);
      check("c_busy_c3", 32'(busy), 32'd1);
      cpu_req = 1'b0;
      tick();
      check("c_busy_c4", 32'(busy), 32'd0);
      check("c_hold_c4", 32'(cpu_data), 32'hB5);

      // simultaneous C (0x0000) and D (0x3FFF)
      cpu_req = 1'b1; cpu_addr = 14'h0000;
      dma_req = 1'b1; dma_addr = 14'h3FFF;
      tick(); tick(); tick();
      check("tie_cack3",  32'(cpu_ack), 32'd1);
      check("tie_cdata3", 32'(cpu_data), 32'hA5);
      check("tie_dack3",  32'(dma_ack), 32'd0);
      cpu_req = 1'b0;
      tick(); tick();
      check("tie_daddr5", 32'(rom_address), 32'h3FFF);
      check("tie_dsel5",  32'(rom_select), 32'd1);
      tick(); tick();
      check("tie_dack7",  32'(dma_ack), 32'd1);
      check("tie_ddata7", 32'(dma_data), 32'h65);
      check("tie_cack7",  32'(cpu_ack), 32'd0);
      dma_req = 1'b0;
      tick();

      // C request dropped after one cycle
      c0 = cpu_acks;
      cpu_req = 1'b1; cpu_addr = 14'h1234;
      tick();
      cpu_req = 1'b0;
      repeat (8) tick();
      check("drop_ackcnt", cpu_acks - c0, 32'd1);
      check("drop_data",   32'(cpu_data), 32'h83);
      check("drop_busy",   32'(busy), 32'd0);

      // reset held 3 cycles in the middle of an access
      cpu_req = 1'b1; cpu_addr = 14'h0020;
      tick();
      check("mid_sel", 32'(rom_select), 32'd1);
      rst = 1'b1; cpu_req = 1'b0;
      c0 = cpu_acks;
      tick(); tick(); tick();
      check("mrst_outs", 32'({rom_select, busy, cpu_ack, dma_ack}), 32'd0);
      check("mrst_addr", 32'(rom_address), 32'd0);
      check("mrst_data", 32'({cpu_data, dma_data}), 32'd0);
      rst = 1'b0;
      repeat (6) tick();
      check("mrst_noack", cpu_acks - c0, 32'd0);
      cpu_req = 1'b1; cpu_addr = 14'h0040;
      tick(); tick(); tick();
      check("post_ack",  32'(cpu_ack), 32'd1);
      check("post_data", 32'(cpu_data), 32'hE5);
      cpu_req = 1'b0;
      tick();

      // C and D both held continuously for 64 cycles
      c0 = cpu_acks; d0 = dma_acks;
      cpu_req = 1'b1; cpu_addr = 14'h0100;
      dma_req = 1'b1; dma_addr = 14'h0200;
      repeat (64) tick();
      cpu_req = 1'b0; dma_req = 1'b0;
`ifdef FIRMWARE_ARB_FAIRNESS_EN
      check("starve_dacks", dma_acks - d0, 32'd3);
      check("starve_cacks", cpu_acks - c0, 32'd13);
`else
      check("starve_dacks", dma_acks - d0, 32'd0);
      check("starve_cacks", cpu_acks - c0, 32'd16);
`endif
      tick(); tick();
      check("starve_idle", 32'(busy), 32'd0);

      // random scoreboard: both ports, protocol-compliant requesters
      sb_acks = 0; ca = '0; da = '0;
      for (int cyc = 0; cyc < 4000 && sb_acks < 200; cyc++) begin
         if (cpu_ack) begin
            check("sb_cpu", 32'(cpu_data), 32'(rom_fn(ca)));
            sb_acks++;
            cpu_req = 1'b0;
         end else if (!cpu_req && ($urandom_range(0, 2) == 0)) begin
            ca = 14'($urandom); cpu_addr = ca; cpu_req = 1'b1;
         end
         if (dma_ack) begin
            check("sb_dma", 32'(dma_data), 32'(rom_fn(da)));
            sb_acks++;
            dma_req = 1'b0;
         end else if (!dma_req && ($urandom_range(0, 1) == 0)) begin
            da = 14'($urandom); dma_addr = da; dma_req = 1'b1;
         end
         tick();
      end
      check("sb_done", 32'(sb_acks >= 200), 32'd1);
      cpu_req = 1'b0; dma_req = 1'b0;
      repeat (6) tick();

      check("never_both_ack", both_ack, 32'd0);
      check("sel_only_access", sel_bad, 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
